// File: rtl/link_master.sv
// link_master: initiator side of a 4-phase req/ack byte link.
// Optional ack-wait timeout enabled by defining LINK_MASTER_TIMEOUT_EN.
module link_master #(
    parameter int NBYTES  = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NBYTES*DW-1:0] payload,
    input  logic                 ack,
    output logic                 req,
    output logic [DW-1:0]        data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ_HI,
        S_REQ_LO
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_req;
    logic            w_req_nxt;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [IW-1:0]   w_idx_inc;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            w_load;
    logic            w_last;
    logic            w_tmo;
    logic [DW-1:0]   r_bytes [NBYTES];

    assign w_idx_inc = r_idx + IW'(1);
    assign w_last    = (r_idx == IW'(NBYTES - 1));

`ifdef LINK_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;

    // Wait counter: restarts on every state entry, runs while a handshake is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // Fires on the cycle whose closing edge would bring the count to TIMEOUT
    assign w_tmo = (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_tmo            = 1'b0;
`endif

    // State and registered outputs; reset drops req and abandons any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Payload snapshot taken when a start is accepted
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < NBYTES; i++) begin
                r_bytes[i] <= payload[i*DW +: DW];
            end
        end
    end

    // Next-state and next-output logic for the handshake sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_data_nxt  = payload[DW-1:0];
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_REQ_LO;
                end else if (w_tmo) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ_LO: begin
                if (!ack) begin
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_data_nxt  = r_bytes[w_idx_inc];
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQ_HI;
                    end
                end else if (w_tmo) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req  = r_req;
    assign data = r_data;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_link_master.sv
// tb_link_master: scenario tasks against link_master with a responder model.
// Expected bytes are queued at start and compared with what the responder received.
module tb_link_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] payload = '0;
    logic        ack_force = 1'b0;
    logic        resp_off = 1'b0;
    wire         ack;
    logic        req;
    logic [7:0]  data;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_miss = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];

    logic r_ack;
    int   wait_cnt;
    int   rx_cnt;
    int   slow_byte = -1;
    int   slow_extra = 0;

    assign ack = r_ack | ack_force;

    link_master #(.NBYTES(4), .DW(8), .TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .payload (payload),
        .ack     (ack),
        .req     (req),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Responder: raises ack (optionally late) on req, drops it after req falls
    always @(posedge clk) begin
        if (rst || resp_off) begin
            r_ack    <= 1'b0;
            wait_cnt <= 0;
            rx_cnt   <= 0;
        end else begin
            if (done) rx_cnt <= 0;
            if (req && !r_ack) begin
                if (wait_cnt >= ((rx_cnt == slow_byte) ? slow_extra : 0)) begin
                    r_ack    <= 1'b1;
                    wait_cnt <= 0;
                    rx_q.push_back(data);
                    rx_cnt   <= rx_cnt + 1;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else if (!req && r_ack) begin
                r_ack <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ack_force = 1'b1;
        payload = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (req !== 1'b0) begin n_miss++; $display("FAIL reset_req: got %b want 0", req); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (data !== 8'h00) begin n_miss++; $display("FAIL reset_data: got %h want 00", data); end
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0; start = 1'b0; ack_force = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_idle: got %b want 0", busy); end
    endtask

    task automatic test_nominal();
        logic [31:0] p;
        int rise[$];
        int done_at;
        int ndone;
        logic prev_req;
        p = 32'hDDCCBBAA;
        @(negedge clk);
        payload = p; start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i*8 +: 8]);
        prev_req = req; done_at = -1; ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (req && !prev_req) rise.push_back(k);
            prev_req = req;
            if (done) begin ndone++; done_at = k; end
        end
        n_vec++;
        if (rise.size() != 4) begin n_miss++; $display("FAIL nom_rises: got %0d want 4", rise.size()); end
        for (int i = 0; i < rise.size() && i < 4; i++) begin
            n_vec++;
            if (rise[i] != 1 + 4*i) begin
                n_miss++; $display("FAIL nom_rise%0d: got %0d want %0d", i, rise[i], 1 + 4*i);
            end
        end
        n_vec++; if (ndone != 1) begin n_miss++; $display("FAIL nom_ndone: got %0d want 1", ndone); end
        n_vec++; if (done_at != 17) begin n_miss++; $display("FAIL nom_done_at: got %0d want 17", done_at); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (rx_q.size() == 0) begin n_miss++; $display("FAIL nom_byte: got none want %h", e); end
            else begin
                logic [7:0] g;
                g = rx_q.pop_front();
                if (g !== e) begin n_miss++; $display("FAIL nom_byte: got %h want %h", g, e); end
            end
        end
        n_vec++; if (rx_q.size() != 0) begin n_miss++; $display("FAIL nom_extra: got %0d want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_slow_ack();
        logic [31:0] p;
        int stall;
        int ndone;
        int done_at;
        p = 32'hDDCCBBAA;
        slow_byte = 1; slow_extra = 5;
        @(negedge clk);
        payload = p; start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i*8 +: 8]);
        stall = 0; ndone = 0; done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (req && !ack && rx_cnt == 1) begin
                stall++;
                n_vec++;
                if (data !== 8'hBB) begin n_miss++; $display("FAIL slow_data: got %h want bb", data); end
            end
            if (done) begin ndone++; done_at = k; end
        end
        slow_byte = -1; slow_extra = 0;
        n_vec++; if (stall != 6) begin n_miss++; $display("FAIL slow_stall: got %0d want 6", stall); end
        n_vec++; if (ndone != 1) begin n_miss++; $display("FAIL slow_ndone: got %0d want 1", ndone); end
        n_vec++; if (done_at != 22) begin n_miss++; $display("FAIL slow_done_at: got %0d want 22", done_at); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (rx_q.size() == 0) begin n_miss++; $display("FAIL slow_byte: got none want %h", e); end
            else begin
                logic [7:0] g;
                g = rx_q.pop_front();
                if (g !== e) begin n_miss++; $display("FAIL slow_byte: got %h want %h", g, e); end
            end
        end
        n_vec++; if (rx_q.size() != 0) begin n_miss++; $display("FAIL slow_extra: got %0d want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p1;
        logic [31:0] p2;
        int dcount;
        int c1;
        int d2;
        p1 = 32'h04030201;
        p2 = 32'h08070605;
        dcount = 0; c1 = -1; d2 = -1;
        @(negedge clk);
        payload = p1; start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(p1[i*8 +: 8]);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (c1 >= 0 && k == c1 + 1) begin
                n_vec++; if (req !== 1'b1) begin n_miss++; $display("FAIL b2b_req: got %b want 1", req); end
                n_vec++; if (data !== 8'h05) begin n_miss++; $display("FAIL b2b_data: got %h want 05", data); end
                start = 1'b0;
            end
            if (c1 >= 0 && k == c1 + 6) begin start = 1'b1; payload = 32'hEEEEEEEE; end
            if (c1 >= 0 && k == c1 + 7) start = 1'b0;
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    c1 = k;
                    payload = p2;
                    for (int i = 0; i < 4; i++) exp_q.push_back(p2[i*8 +: 8]);
                end else begin
                    d2 = k;
                end
            end
        end
        start = 1'b0;
        n_vec++; if (c1 != 17) begin n_miss++; $display("FAIL b2b_first_done: got %0d want 17", c1); end
        n_vec++; if (dcount != 2) begin n_miss++; $display("FAIL b2b_ndone: got %0d want 2", dcount); end
        n_vec++; if (d2 - c1 != 17) begin n_miss++; $display("FAIL b2b_second_done: got %0d want 17", d2 - c1); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_idle: got %b want 0", busy); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (rx_q.size() == 0) begin n_miss++; $display("FAIL b2b_byte: got none want %h", e); end
            else begin
                logic [7:0] g;
                g = rx_q.pop_front();
                if (g !== e) begin n_miss++; $display("FAIL b2b_byte: got %h want %h", g, e); end
            end
        end
        n_vec++; if (rx_q.size() != 0) begin n_miss++; $display("FAIL b2b_extra: got %0d want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p;
        int nd;
        int done_at;
        p = 32'h5A4B3C2D;
        nd = 0;
        @(negedge clk);
        payload = p; start = 1'b1;
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h3C);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) nd++;
        end
        n_vec++; if (req !== 1'b1) begin n_miss++; $display("FAIL mid_pre_req: got %b want 1", req); end
        n_vec++; if (data !== 8'h4B) begin n_miss++; $display("FAIL mid_pre_data: got %h want 4b", data); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (req !== 1'b0) begin n_miss++; $display("FAIL mid_req: got %b want 0", req); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (done) nd++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        n_vec++; if (nd != 0) begin n_miss++; $display("FAIL mid_done: got %0d want 0", nd); end
        p = 32'h11223344;
        payload = p; start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i*8 +: 8]);
        done_at = -1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) done_at = k;
        end
        n_vec++; if (done_at != 17) begin n_miss++; $display("FAIL mid_restart_done: got %0d want 17", done_at); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (rx_q.size() == 0) begin n_miss++; $display("FAIL mid_byte: got none want %h", e); end
            else begin
                logic [7:0] g;
                g = rx_q.pop_front();
                if (g !== e) begin n_miss++; $display("FAIL mid_byte: got %h want %h", g, e); end
            end
        end
        n_vec++; if (rx_q.size() != 0) begin n_miss++; $display("FAIL mid_extra: got %0d want 0", rx_q.size()); rx_q.delete(); end
    endtask

    task automatic test_timeout();
        int nerr;
        int err_at;
        nerr = 0; err_at = -1;
        @(negedge clk);
        resp_off = 1'b1;
        payload = 32'hA1B2C3D4; start = 1'b1;
`ifdef LINK_MASTER_TIMEOUT_EN
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (err) begin
                nerr++; err_at = k;
                n_vec++; if (req !== 1'b0) begin n_miss++; $display("FAIL tmo_req: got %b want 0", req); end
                n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL tmo_busy: got %b want 0", busy); end
                n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL tmo_done: got %b want 0", done); end
            end
        end
        n_vec++; if (nerr != 1) begin n_miss++; $display("FAIL tmo_nerr: got %0d want 1", nerr); end
        n_vec++; if (err_at != 9) begin n_miss++; $display("FAIL tmo_err_at: got %0d want 9", err_at); end
        resp_off = 1'b0;
        begin
            logic [31:0] p;
            int done_at;
            p = 32'h87654321;
            payload = p; start = 1'b1;
            for (int i = 0; i < 4; i++) exp_q.push_back(p[i*8 +: 8]);
            done_at = -1;
            for (int k = 1; k <= 24; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (done) done_at = k;
            end
            n_vec++; if (done_at != 17) begin n_miss++; $display("FAIL tmo_restart_done: got %0d want 17", done_at); end
        end
`else
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (err) nerr++;
        end
        n_vec++; if (nerr != 0) begin n_miss++; $display("FAIL tmo_off_err: got %0d want 0", nerr); end
        n_vec++; if (req !== 1'b1) begin n_miss++; $display("FAIL tmo_off_wait: got %b want 1", req); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resp_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (rx_q.size() == 0) begin n_miss++; $display("FAIL tmo_byte: got none want %h", e); end
            else begin
                logic [7:0] g;
                g = rx_q.pop_front();
                if (g !== e) begin n_miss++; $display("FAIL tmo_byte: got %h want %h", g, e); end
            end
        end
        n_vec++; if (rx_q.size() != 0) begin n_miss++; $display("FAIL tmo_extra: got %0d want 0", rx_q.size()); rx_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_slow_ack();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
